alu_arbiter: RTL

Two-requester scheduler that shares one 16-bit ALU instance (opcodes 0–7: ADD, AND, PASS A, PASS B, NOT A, MUL, SHL, SRA).
- Arbitrates requests round-robin and latches the winner's operands and opcode.
- Drives the ALU from registers and waits a fixed settle time (longer for MUL).
- Captures Z/OF/CC into result registers and pulses a per-requester DONE.
- Sits between the register-file/decode logic and the ALU.

---
 rtl/alu_arbiter_pkg.sv | 33 +++
 rtl/alu_arbiter_rr_arb2.sv | 37 +++
 rtl/alu_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_pkg
// Purpose  : Shared opcodes, widths and FSM encoding for the ALU arbiter.
// Revision : 1.0  initial release
// ============================================================================
package alu_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 4;
    localparam int CC_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
    localparam logic [OP_W-1:0] OP_AND   = 4'd1;
    localparam logic [OP_W-1:0] OP_PASSA = 4'd2;
    localparam logic [OP_W-1:0] OP_PASSB = 4'd3;
    localparam logic [OP_W-1:0] OP_NOTA  = 4'd4;
    localparam logic [OP_W-1:0] OP_MUL   = 4'd5;
    localparam logic [OP_W-1:0] OP_SHL   = 4'd6;
    localparam logic [OP_W-1:0] OP_SRA   = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic op_illegal(input logic [OP_W-1:0] op);
        return op[OP_W-1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-input round-robin arbiter; pointer advances on update.
// Revision : 1.0  initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // r_ptr = 0 favours req[0], r_ptr = 1 favours req[1]
    logic r_ptr;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (update && (|grant)) begin
            r_ptr <= grant[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one ALU between two requesters; grant, settle, capture.
// Revision : 1.0  initial release
// ============================================================================
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int MUL_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [OP_W-1:0]   op0,
    input  logic [OP_W-1:0]   op1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] b1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_control,
    input  logic [DATA_W-1:0] alu_z,
    input  logic [DATA_W-1:0] alu_of,
    input  logic [CC_W-1:0]   alu_cc,
    output logic [DATA_W-1:0] res_z,
    output logic [DATA_W-1:0] res_of,
    output logic [CC_W-1:0]   res_cc,
    output logic              err,
    output logic              busy
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_load;
    logic                w_cnt_dec;
    logic                w_capture;
    logic [1:0]          w_gnt;
    logic                w_win;
    logic [OP_W-1:0]     w_op_sel;

    logic [CNT_W-1:0]    r_cnt;
    logic                r_owner;
    logic [1:0]          r_gnt;
    logic [1:0]          r_done;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [OP_W-1:0]     r_alu_control;
    logic [DATA_W-1:0]   r_res_z;
    logic [DATA_W-1:0]   r_res_of;
    logic [CC_W-1:0]     r_res_cc;
    logic                r_err;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1, req0}),
        .update (w_load),
        .grant  (w_gnt)
    );

    assign w_win    = w_gnt[1];
    assign w_op_sel = w_win ? op1 : op0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_cnt_dec   = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (r_cnt != '0) begin
                    w_cnt_dec = 1'b1;
                end else begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant/done are single-cycle pulses; ALU operands hold between ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_owner       <= 1'b0;
            r_gnt         <= 2'b00;
            r_done        <= 2'b00;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_control <= '0;
            r_res_z       <= '0;
            r_res_of      <= '0;
            r_res_cc      <= '0;
            r_err         <= 1'b0;
        end else begin
            r_gnt  <= 2'b00;
            r_done <= 2'b00;
            if (w_load) begin
                r_gnt         <= w_gnt;
                r_owner       <= w_win;
                r_alu_a       <= w_win ? a1 : a0;
                r_alu_b       <= w_win ? b1 : b0;
                r_alu_control <= w_op_sel;
                r_cnt         <= (w_op_sel == OP_MUL) ? C_MUL_LOAD : '0;
            end
            if (w_cnt_dec) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_capture) begin
                r_done[r_owner] <= 1'b1;
                if (op_illegal(r_alu_control)) begin
                    r_res_z  <= '0;
                    r_res_of <= '0;
                    r_res_cc <= '0;
                    r_err    <= 1'b1;
                end else begin
                    r_res_z  <= alu_z;
                    r_res_of <= alu_of;
                    r_res_cc <= alu_cc;
                    r_err    <= 1'b0;
                end
            end
        end
    end

    assign gnt0        = r_gnt[0];
    assign gnt1        = r_gnt[1];
    assign done0       = r_done[0];
    assign done1       = r_done[1];
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_control = r_alu_control;
    assign res_z       = r_res_z;
    assign res_of      = r_res_of;
    assign res_cc      = r_res_cc;
    assign err         = r_err;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire
